key_debounce: RTL and testbench



---
 rtl/key_debounce.sv | 79 +++++++
 tb/tb_key_debounce.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// key_debounce: synchronizes, polarity-normalizes and debounces raw key lines.
// A bit toggles only after its new level holds for STABLE_TICKS prescaler ticks.
module key_debounce #(
    parameter int WIDTH        = 20,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 8,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_out,
    output logic             key_change
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [WIDTH-1:0] IDLE = {WIDTH{ACTIVE_LOW != 0}};
    localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CLAST = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] samp;
    logic [WIDTH-1:0] toggle;
    logic [PW-1:0]    pcnt;
    logic             tick;
    logic [CW-1:0]    cnt [WIDTH];

    assign samp = sync2 ^ IDLE;
    assign tick = (pcnt == PLAST);

    always_comb begin
        toggle = '0;
        for (int i = 0; i < WIDTH; i++) begin
            toggle[i] = (samp[i] != key_out[i]) && tick && (cnt[i] == CLAST);
        end
    end

    // Reset loads the idle pin level so release never looks like a press
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= IDLE;
            sync2 <= IDLE;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_out    <= '0;
            key_change <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            key_out    <= key_out ^ toggle;
            key_change <= |toggle;
            for (int i = 0; i < WIDTH; i++) begin
                if ((samp[i] == key_out[i]) || toggle[i]) begin
                    cnt[i] <= '0;
                end else if (tick) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: table vectors, hand-written corner sequences and random
// stimulus against an arithmetic tick-counting reference model.
module tb_key_debounce;

    localparam int W  = 20;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam logic [W-1:0] IDLE = '1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] key_raw = '1;
    logic [W-1:0] key_out;
    logic         key_change;
    logic [W-1:0] raw2 = '0;
    logic [W-1:0] out2;
    logic         chg2;

    always #5 clk = ~clk;

    key_debounce #(
        .WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .key_raw(key_raw),
        .key_out(key_out), .key_change(key_change)
    );

    key_debounce #(
        .WIDTH(W), .TICK_DIV(1), .STABLE_TICKS(1), .ACTIVE_LOW(0)
    ) dut2 (
        .clk(clk), .reset(reset), .key_raw(raw2),
        .key_out(out2), .key_change(chg2)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string name, input int act,
                           input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference: a bit flips once the number of tick edges spanned by its
    // current uninterrupted mismatch run reaches ST.
    logic [W-1:0] h1, h2, m_out, ms;
    logic         m_chg;
    int           n;
    int           st [W];

    always @(posedge clk) begin
        if (reset) begin
            h1 = IDLE; h2 = IDLE; n = 0;
            m_out = '0; m_chg = 1'b0;
            for (int i = 0; i < W; i++) st[i] = -1;
        end else begin
            ms = h2 ^ IDLE;
            m_chg = 1'b0;
            for (int i = 0; i < W; i++) begin
                if (ms[i] == m_out[i]) begin
                    st[i] = -1;
                end else begin
                    if (st[i] < 0) st[i] = n;
                    if ((n + 1) / TD - st[i] / TD == ST) begin
                        m_out[i] = ~m_out[i];
                        m_chg = 1'b1;
                        st[i] = -1;
                    end
                end
            end
            h2 = h1; h1 = key_raw; n++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_key_out", key_out, m_out);
            chk("model_key_change", key_change, m_chg);
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic watch(input int b, input logic v, input int ncyc,
                         output int lat, output int pulses,
                         output logic chg_at);
        lat = -1; pulses = 0; chg_at = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (key_change) pulses++;
            if (lat < 0 && key_out[b] === v) begin
                lat = c;
                chg_at = key_change;
            end
        end
    endtask

    typedef struct {
        logic [W-1:0] raw;
        int           hold;
        logic [W-1:0] exp_out;
        int           exp_pulses;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int lat, lat19, pulses, hi;
        logic ca;
        logic [W-1:0] mask;

        vecs = '{
            '{20'hFFFFF, 20, 20'h00000, 0},
            '{20'hFFFFE, 20, 20'h00001, 1},
            '{20'hFFFFF, 20, 20'h00000, 1},
            '{20'h7FFFE, 20, 20'h80001, 1},
            '{20'hFFFFF, 20, 20'h00000, 1},
            '{20'hFFFF0, 20, 20'h0000F, 1},
            '{20'hFFFFF,  5, 20'h0000F, 0},
            '{20'hFFFF0, 20, 20'h0000F, 0},
            '{20'hFFFF5, 20, 20'h0000A, 1},
            '{20'h0FFFF, 20, 20'hF0000, 1},
            '{20'hFFFFF, 20, 20'h00000, 1}
        };

        repeat (2) @(negedge clk);
        chk("reset_key_out", key_out, 0);
        chk("reset_key_change", key_change, 0);
        chk_en = 1;
        reset = 1'b0;

        // Clean press and release
        key_raw[0] = 1'b0;
        watch(0, 1'b1, 30, lat, pulses, ca);
        chk_rng("t1_rise_latency", lat, 11, 14);
        chk("t1_rise_pulses", pulses, 1);
        chk("t1_pulse_aligned", ca, 1);
        chk("t1_key_out", key_out, 20'h00001);
        key_raw[0] = 1'b1;
        watch(0, 1'b0, 30, lat, pulses, ca);
        chk_rng("t1_fall_latency", lat, 11, 14);
        chk("t1_fall_pulses", pulses, 1);

        // Bounce on bit 5
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (c % 3 == 0) key_raw[5] = ~key_raw[5];
            @(negedge clk);
            if (key_change) pulses++;
        end
        key_raw[5] = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (key_change) pulses++;
        end
        chk("t2_bounce_out", key_out, 0);
        chk("t2_bounce_pulses", pulses, 0);

        // Simultaneous bits 0 and 19
        key_raw = 20'h7FFFE;
        lat = -1; lat19 = -1; pulses = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (key_change) pulses++;
            if (lat < 0 && key_out[0]) lat = c;
            if (lat19 < 0 && key_out[19]) lat19 = c;
        end
        chk("t3_same_cycle", lat19, lat);
        chk_rng("t3_latency", lat, 11, 14);
        chk("t3_key_out", key_out, 20'h80001);
        chk("t3_pulses", pulses, 1);
        key_raw = IDLE;
        repeat (20) @(negedge clk);

        // Reset mid-count
        do_reset();
        key_raw[3] = 1'b0;
        pulses = 0; hi = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (key_change) pulses++;
            if (key_out != 0) hi++;
        end
        chk("t4_pre_reset_out", hi, 0);
        chk("t4_pre_reset_pulses", pulses, 0);
        do_reset();
        watch(3, 1'b1, 30, lat, pulses, ca);
        chk_rng("t4_post_reset_latency", lat, 11, 14);
        chk("t4_post_reset_pulses", pulses, 1);
        key_raw = IDLE;
        repeat (20) @(negedge clk);

        // Repeated reset with idle pins
        for (int k = 0; k < 8; k++) begin
            reset = 1'b1;
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                chk("t5_quiet", {key_out, key_change}, 0);
            end
            reset = 1'b0;
            repeat ($urandom_range(1, 5)) begin
                @(negedge clk);
                chk("t5_quiet", {key_out, key_change}, 0);
            end
        end

        // Table vectors
        for (int v = 0; v < 11; v++) begin
            key_raw = vecs[v].raw;
            pulses = 0;
            repeat (vecs[v].hold) begin
                @(negedge clk);
                if (key_change) pulses++;
            end
            chk($sformatf("vec%0d_out", v), key_out, vecs[v].exp_out);
            chk($sformatf("vec%0d_pulses", v), pulses, vecs[v].exp_pulses);
        end

        // Active-high, TICK_DIV=1, STABLE_TICKS=1
        do_reset();
        raw2[7] = 1'b1;
        lat = -1; pulses = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (chg2) pulses++;
            if (lat < 0 && out2[7]) lat = c;
        end
        chk("t6_rise_latency", lat, 3);
        chk("t6_out", out2, 20'h00080);
        chk("t6_pulses", pulses, 1);
        raw2[7] = 1'b0;
        lat = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (lat < 0 && !out2[7]) lat = c;
        end
        chk("t6_fall_latency", lat, 3);
        raw2[7] = 1'b1;
        @(negedge clk);
        raw2[7] = 1'b0;
        lat = -1; hi = 0; pulses = 0;
        for (int c = 2; c <= 10; c++) begin
            @(negedge clk);
            if (chg2) pulses++;
            if (out2[7]) hi++;
            if (lat < 0 && out2[7]) lat = c;
        end
        chk("t6_glitch_latency", lat, 3);
        chk("t6_glitch_width", hi, 1);
        chk("t6_glitch_pulses", pulses, 2);

        // Random bouncy stimulus against the model
        for (int s = 0; s < 200; s++) begin
            if ($urandom_range(0, 29) == 0) begin
                do_reset();
            end else begin
                mask = W'($urandom & $urandom & $urandom);
                key_raw = IDLE & ~mask;
                repeat ($urandom_range(1, 24)) @(negedge clk);
            end
        end
        key_raw = IDLE;
        repeat (20) @(negedge clk);
        chk("final_idle_out", key_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
